// File: rtl/indication_output_fifo.sv
// indication_output_fifo
// Tags indication calls from NUM_METHODS methods with their method number
// (1..NUM_METHODS). It buffers them in a DEPTH-entry ring FIFO and drains
// them in order onto a single pipe enq interface.
// Optional feature macro: INDICATION_FIFO_BYPASS_EN. When it is defined, a
// call that arrives while the FIFO is empty and the pipe is ready goes
// straight to the pipe in the same cycle.
module indication_output_fifo #(
  parameter int NUM_METHODS = 2,
  parameter int NUM_ARGS    = 2,
  parameter int ARG_WIDTH   = 32,
  parameter int TAG_WIDTH   = 32,
  parameter int DEPTH       = 4,
  localparam int PIPE_W     = TAG_WIDTH + NUM_ARGS * ARG_WIDTH,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [NUM_METHODS-1:0]                  indication__ENA,
  input  logic [NUM_METHODS*NUM_ARGS*ARG_WIDTH-1:0] indication_args,
  output logic [NUM_METHODS-1:0]                  indication__RDY,
  output logic                                    pipe_enq__ENA,
  output logic [PIPE_W-1:0]                       pipe_enq_v,
  input  logic                                    pipe_enq__RDY,
  output logic [CNT_W-1:0]                        count,
  output logic                                    drop_err
);

  localparam int SLICE_W = NUM_ARGS * ARG_WIDTH;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int IDX_W   = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;

  logic [PIPE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic [IDX_W-1:0]  sel_idx;
  logic [PIPE_W-1:0] sel_word;
  logic              collision;
  logic              full;
  logic              empty;
  logic              ready;
  logic              accept;
  logic              head_deq;
  logic              bypass;
  logic              store;

  // Pick the lowest-numbered active method and build its tagged word
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_METHODS - 1; i >= 0; i--) begin
      if (indication__ENA[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
    sel_word  = {TAG_WIDTH'(sel_idx) + TAG_WIDTH'(1),
                 indication_args[sel_idx*SLICE_W +: SLICE_W]};
    collision = (indication__ENA & (indication__ENA - NUM_METHODS'(1))) != '0;
  end

  // Occupancy-based handshakes; full and empty never come from pointer compare
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    empty    = (count == '0);
    ready    = !RST && !full;
    accept   = ready && (|indication__ENA);
    head_deq = !RST && !empty && pipe_enq__RDY;
`ifdef INDICATION_FIFO_BYPASS_EN
    bypass   = accept && empty && pipe_enq__RDY;
`else
    bypass   = 1'b0;
`endif
    store           = accept && !bypass;
    indication__RDY = {NUM_METHODS{ready}};
    pipe_enq__ENA   = head_deq || bypass;
    if (bypass) begin
      pipe_enq_v = sel_word;
    end else if (!empty) begin
      pipe_enq_v = mem[rd_ptr];
    end else begin
      pipe_enq_v = '0;
    end
  end

  // Ring storage, pointers, occupancy and the sticky collision flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (store) begin
        mem[wr_ptr] <= sel_word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (head_deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(store) - CNT_W'(head_deq);
      if (accept && collision) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_indication_output_fifo.sv
// tb_indication_output_fifo
// Scoreboard bench for indication_output_fifo. The driver pushes the expected
// pipe word whenever its queue model says a call is accepted. A negedge
// monitor pops and compares every word the DUT presents, and also checks
// count, ready and drop_err.
module tb_indication_output_fifo;

  localparam int NM      = 2;
  localparam int NA      = 2;
  localparam int AW      = 32;
  localparam int TW      = 32;
  localparam int DEPTH   = 4;
  localparam int SLICE_W = NA * AW;
  localparam int PIPE_W  = TW + SLICE_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [NM-1:0]        ena = '0;
  logic [NM*SLICE_W-1:0] args = '0;
  logic [NM-1:0]        rdy_out;
  logic                 pipe_ena;
  logic [PIPE_W-1:0]    pipe_v;
  logic                 pipe_rdy = 1'b0;
  logic [CNT_W-1:0]     count;
  logic                 drop_err;

  logic [PIPE_W-1:0] exp_q[$];
  int  model_count = 0;
  bit  model_drop  = 1'b0;
  bit  exp_ena_now = 1'b0;
  bit  exp_byp_now = 1'b0;
  bit  check_en    = 1'b0;
  int  total = 0;
  int  bad   = 0;

  indication_output_fifo #(
    .NUM_METHODS(NM), .NUM_ARGS(NA), .ARG_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH(DEPTH)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .indication__ENA (ena),
    .indication_args (args),
    .indication__RDY (rdy_out),
    .pipe_enq__ENA   (pipe_ena),
    .pipe_enq_v      (pipe_v),
    .pipe_enq__RDY   (pipe_rdy),
    .count           (count),
    .drop_err        (drop_err)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus; called just after a posedge, returns just after the next
  task automatic applyStimulus(input logic [NM-1:0] e, input logic [NM*SLICE_W-1:0] a,
                               input logic prdy, input logic rst);
    bit acc;
    bit deq;
    bit byp;
    bit multi;
    int sel;
    ena      = e;
    args     = a;
    pipe_rdy = prdy;
    RST      = rst;
    acc   = !rst && (e != '0) && (model_count != DEPTH);
    deq   = !rst && (model_count != 0) && prdy;
    byp   = 1'b0;
`ifdef INDICATION_FIFO_BYPASS_EN
    byp   = acc && (model_count == 0) && prdy;
`endif
    multi = ($countones(e) > 1);
    exp_ena_now = deq || byp;
    exp_byp_now = byp;
    if (acc) begin
      sel = -1;
      for (int i = 0; i < NM; i++) begin
        if (e[i] && sel < 0) sel = i;
      end
      exp_q.push_back({TW'(sel + 1), a[sel*SLICE_W +: SLICE_W]});
    end
    @(posedge CLK);
    #1;
    if (rst) begin
      exp_q.delete();
      model_count = 0;
      model_drop  = 1'b0;
    end else begin
      model_count = model_count + int'(acc && !byp) - int'(deq);
      if (acc && multi) model_drop = 1'b1;
    end
  endtask

  function automatic logic [NM*SLICE_W-1:0] randArgs();
    logic [NM*SLICE_W-1:0] r;
    for (int i = 0; i < NM * NA; i++) begin
      r[i*AW +: AW] = $urandom;
    end
    return r;
  endfunction

  // Monitor: compare DUT outputs against the model in the middle of each cycle
  always @(negedge CLK) begin
    if (check_en) begin
      checkOutput("pipe_ena", 128'(pipe_ena), 128'(exp_ena_now));
      checkOutput("count", 128'(count), 128'(model_count));
      checkOutput("ind_rdy", 128'(rdy_out),
                  128'({NM{!RST && (model_count != DEPTH)}}));
      checkOutput("drop_err", 128'(drop_err), 128'(model_drop));
      if (pipe_ena) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL pipe_word_unexpected: got %0h expected none", pipe_v);
        end else begin
          checkOutput("pipe_word", 128'(pipe_v), 128'(exp_q.pop_front()));
        end
      end else if (model_count == 0 && !exp_byp_now) begin
        checkOutput("pipe_idle_zero", 128'(pipe_v), 128'(0));
      end
    end
  end

  initial begin
    logic [NM*SLICE_W-1:0] a;
    int drain;
    int r;
    logic [NM-1:0] e;

    $display("[TB] reset");
    applyStimulus('0, '0, 1'b0, 1'b1);
    check_en = 1'b1;
    applyStimulus('0, '0, 1'b1, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b0);

    $display("[TB] single call on method 0");
    a = '0;
    a[31:0]  = 32'h11;
    a[63:32] = 32'h22;
    applyStimulus(2'b01, a, 1'b1, 1'b0);
    #3;
    checkOutput("first_word_literal", 128'(pipe_v), 128'(96'h00000001_00000022_00000011));
    checkOutput("first_word_ena", 128'(pipe_ena), 128'(1));
    applyStimulus('0, '0, 1'b1, 1'b0);
    applyStimulus('0, '0, 1'b1, 1'b0);

    $display("[TB] fill under backpressure, drain in order");
    for (int i = 0; i < 4; i++) applyStimulus((i % 2 == 0) ? 2'b01 : 2'b10, randArgs(), 1'b0, 1'b0);
    applyStimulus(2'b01, randArgs(), 1'b0, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus('0, '0, 1'b1, 1'b0);

    $display("[TB] full with held call, pointer wrap");
    for (int i = 0; i < 4; i++) applyStimulus(2'b10, randArgs(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(2'b01, randArgs(), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus('0, '0, 1'b1, 1'b0);

    $display("[TB] collision");
    applyStimulus(2'b11, randArgs(), 1'b0, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b1, 1'b0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) applyStimulus(2'b10, randArgs(), 1'b0, 1'b0);
    applyStimulus('0, '0, 1'b1, 1'b1);
    applyStimulus(2'b01, randArgs(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b1, 1'b0);

`ifdef INDICATION_FIFO_BYPASS_EN
    $display("[TB] bypass call on method 1");
    a = '0;
    a[95:64]  = 32'd5;
    a[127:96] = 32'd6;
    applyStimulus(2'b10, a, 1'b1, 1'b0);
    applyStimulus('0, '0, 1'b1, 1'b0);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      e = 2'b00;
      else if (r < 60) e = 2'b01;
      else if (r < 90) e = 2'b10;
      else             e = 2'b11;
      applyStimulus(e, randArgs(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
    end

    drain = 0;
    while (model_count != 0 && drain < 20) begin
      applyStimulus('0, '0, 1'b1, 1'b0);
      drain++;
    end
    applyStimulus('0, '0, 1'b1, 1'b0);
    checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/indication_output_fifo.md
Name: indication_output_fifo

Overview:
- Parametrised successor to the two-entry ping-pong indication serializer.
- Accepts indication method calls from NUM_METHODS methods and tags each with its method number.
- Buffers the tagged messages in a DEPTH-entry ring FIFO and drains them in order onto a single pipe enq interface.
- Sits between a device-side module's indication port and the portal/pipe transport.

Parameters:
- NUM_METHODS, 2: number of indication methods; tags issued are 1..NUM_METHODS.
- NUM_ARGS, 2: 32-bit-style arguments per method.
- ARG_WIDTH, 32: width of each argument.
- TAG_WIDTH, 32: width of the tag field.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- Derived: PIPE_W = TAG_WIDTH + NUM_ARGS*ARG_WIDTH (default 96). CNT_W = $clog2(DEPTH+1).

Ports:
- CLK  in  1  clock; all state on posedge.
- RST  in  1  reset; synchronous, active-high.
- indication__ENA  in  NUM_METHODS  per-method call strobe; bit i = method i.
- indication$args  in  NUM_METHODS*NUM_ARGS*ARG_WIDTH  method i occupies slice i; arg0 is the low ARG_WIDTH of that slice.
- indication__RDY  out  NUM_METHODS  per-method ready; all bits identical.
- pipe$enq__ENA  out  1  pipe word valid this cycle.
- pipe$enq$v  out  PIPE_W  word = {tag, argN-1 … arg0}; tag in the MSBs, arg0 in the LSBs.
- pipe$enq__RDY  in  1  transport can accept a word.
- count  out  CNT_W  current occupancy.
- drop_err  out  1  sticky error: a collision occurred.

Behaviour:
- Reset (RST high at posedge):
  - wr_ptr=0, rd_ptr=0, count=0, drop_err=0; storage cleared to 0.
  - While RST is high, indication__RDY=0 and pipe$enq__ENA=0.
- indication__RDY[i] = !RST && (count != DEPTH). It is combinational from count only and must not depend on pipe$enq__RDY.
- Enqueue:
  - A call is accepted on a posedge where any ENA bit is set and RDY is high.
  - Entry[wr_ptr] <= {i+1 (zero-extended to TAG_WIDTH), args of method i}.
  - wr_ptr increments mod DEPTH.
- Collision (more than one ENA bit set in the same cycle):
  - Only the lowest index i is enqueued; the others are discarded.
  - drop_err <= 1 and stays set until RST.
- ENA asserted while RDY is low is a caller violation. Nothing is stored and state is unchanged.
- Dequeue:
  - pipe$enq__ENA = (count != 0) && pipe$enq__RDY.
  - pipe$enq$v = entry[rd_ptr] whenever count != 0; otherwise 0.
  - On a posedge with pipe$enq__ENA, rd_ptr increments mod DEPTH.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
  - When full: RDY is low, so only the dequeue happens. The freed slot is visible via RDY the following cycle.
  - When empty: only the enqueue happens; there is no pass-through unless the optional feature is enabled.
- Latency: a message accepted at posedge t is presented on the pipe from cycle t+1 if the FIFO was empty.
- Ordering is strict FIFO across all methods.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are taken from count, never from pointer equality.
- Backpressure: while pipe$enq__RDY is low, the head entry and pipe$enq$v are held stable.
- Reset mid-operation: all queued entries are discarded. No pipe$enq__ENA is asserted in the cycle following reset deassertion unless a new enqueue occurred.

Optional Feature:
- Macro: INDICATION_FIFO_BYPASS_EN.
- Defined: when count==0, an ENA is accepted, and pipe$enq__RDY is high, the tagged word is driven on pipe$enq$v with pipe$enq__ENA=1 in the same cycle. It is not written to storage, and pointers and count are unchanged. This adds a combinational path from indication to pipe$enq$v/ENA.
- Undefined: minimum latency is one cycle; there is no combinational path from indication inputs to pipe outputs.

Test Plan:
- Reset, then a single call on method 0 with args (0x11, 0x22) and pipe RDY=1 -> next cycle pipe ENA=1 and v=0x00000001_00000022_00000011; count returns 0 after that cycle.
- Pipe RDY=0; enqueue 4 calls alternating methods 0/1 -> count=4, RDY=0. A 5th ENA is ignored. Raise pipe RDY -> 4 words drain in order with tags 1,2,1,2.
- Full FIFO with pipe RDY=1 and a new ENA held -> dequeue proceeds, RDY rises the next cycle, and the new word is enqueued then. Run 10 enq/deq cycles to check pointer wrap with no loss or duplication.
- ENA=2'b11 in one cycle with args A (method 0) and B (method 1) -> only tag 1 / args A is queued; drop_err=1 and stays 1 until RST.
- Queue 3 entries, assert RST for 1 cycle -> count=0, pipe ENA=0, drop_err=0; the next single call emerges as the first word.
- With INDICATION_FIFO_BYPASS_EN, empty FIFO, pipe RDY=1, call method 1 with args (5,6) -> same-cycle pipe ENA=1, v tag=2, count stays 0.
